// File: rtl/send_arb_pkg.sv
// Shared types and helpers for the SEND/ACK channel arbiter and its synchroniser.
package send_arb_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned RR_MAX_REQ      = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_REQ_LO = 2'd2,
    WAIT_ACK_LO = 2'd3
  } arb_state_e;

  // First set request at or after ptr, wrapping modulo n (n <= RR_MAX_REQ).
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr,
                                         input logic [RR_MAX_REQ-1:0] req,
                                         input logic [3:0] n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      idx = 4'(ptr) + 4'(i);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(i) < n) && req[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/send_arbiter_ack_sync.sv
// Multi-flop synchroniser for a level signal crossing into the local clock domain.
module ack_synchronizer
  import send_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/send_arbiter.sv
// Round-robin arbiter sharing one four-phase SEND/ACK/DATA channel among NUM_REQ requesters.
// Define SEND_ARB_TIMEOUT_EN to add the WAIT_ACK_HI timeout and the outTIMEOUT_arb port.
module send_arbiter
  import send_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
`ifdef SEND_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                        clk_arb,
  input  logic                        rst_arb,
  input  logic [NUM_REQ-1:0]          inSEND_arb,
  input  logic [NUM_REQ*DATA_W-1:0]   inDATA_arb,
  output logic [NUM_REQ-1:0]          outACK_arb,
  input  logic                        ACK_arb,
  output logic                        outSEND_arb,
  output logic [DATA_W-1:0]           outDATA_arb,
  output logic [NUM_REQ-1:0]          outGRANT_arb
`ifdef SEND_ARB_TIMEOUT_EN
  ,
  output logic                        outTIMEOUT_arb
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic               send_q, send_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   pick_c;
  logic               ack_s;

`ifdef SEND_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  ack_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk     (clk_arb),
    .rst_n   (rst_arb),
    .async_i (ACK_arb),
    .sync_o  (ack_s)
  );

  assign pick_c = PTR_W'(rr_pick(3'(ptr_q), 8'(inSEND_arb), 4'(NUM_REQ)));

  // Handshake sequencing and next-state for every registered output.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    send_d  = send_q;
    data_d  = data_q;
    ack_d   = ack_q;
    grant_d = grant_q;
`ifdef SEND_ARB_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|inSEND_arb) begin
          win_d   = pick_c;
          data_d  = inDATA_arb[32'(pick_c)*DATA_W +: DATA_W];
          grant_d = NUM_REQ'(1) << pick_c;
          send_d  = 1'b1;
          state_d = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          ack_d   = NUM_REQ'(1) << win_q;
          state_d = WAIT_REQ_LO;
        end
`ifdef SEND_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          send_d    = 1'b0;
          timeout_d = 1'b1;
          state_d   = WAIT_ACK_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      WAIT_REQ_LO: begin
        if (!inSEND_arb[win_q]) begin
          ack_d   = '0;
          send_d  = 1'b0;
          state_d = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          grant_d = '0;
          ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      grant_q <= '0;
`ifdef SEND_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      send_q  <= send_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
`ifdef SEND_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign outSEND_arb  = send_q;
  assign outDATA_arb  = data_q;
  assign outACK_arb   = ack_q;
  assign outGRANT_arb = grant_q;
`ifdef SEND_ARB_TIMEOUT_EN
  assign outTIMEOUT_arb = timeout_q;
`endif

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter: directed handshake scenarios plus randomized traffic against a transaction-level round-robin model.
module tb_send_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int TO = 8;

  logic            clk_arb;
  logic            rst_arb;
  logic [N-1:0]    inSEND_arb;
  logic [N*DW-1:0] inDATA_arb;
  logic [N-1:0]    outACK_arb;
  logic            ACK_arb;
  logic            outSEND_arb;
  logic [DW-1:0]   outDATA_arb;
  logic [N-1:0]    outGRANT_arb;
`ifdef SEND_ARB_TIMEOUT_EN
  logic            outTIMEOUT_arb;
`endif

  send_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .SYNC_STAGES(SS)
`ifdef SEND_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk_arb      (clk_arb),
    .rst_arb      (rst_arb),
    .inSEND_arb   (inSEND_arb),
    .inDATA_arb   (inDATA_arb),
    .outACK_arb   (outACK_arb),
    .ACK_arb      (ACK_arb),
    .outSEND_arb  (outSEND_arb),
    .outDATA_arb  (outDATA_arb),
    .outGRANT_arb (outGRANT_arb)
`ifdef SEND_ARB_TIMEOUT_EN
    , .outTIMEOUT_arb (outTIMEOUT_arb)
`endif
  );

  initial clk_arb = 1'b0;
  always #5 clk_arb = ~clk_arb;

  // Requester-side state driven onto the DUT inputs.
  logic [N-1:0]  req_send;
  logic [DW-1:0] req_data [N];
  always_comb begin
    inSEND_arb = req_send;
    for (int i = 0; i < N; i++) inDATA_arb[i*DW +: DW] = req_data[i];
  end

  int unsigned   n_vec;
  int unsigned   n_err;
  int            ptr_m;
  int            grant_log [$];
  logic [DW-1:0] data_log  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_model(input int ptr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_arb);
    #1;
  endtask

  task automatic do_reset();
    rst_arb = 1'b0;
    ACK_arb = 1'b0;
    #1;
    chk("rst_send", 64'(outSEND_arb), 64'd0);
    chk("rst_ack", 64'(outACK_arb), 64'd0);
    chk("rst_grant", 64'(outGRANT_arb), 64'd0);
    chk("rst_data", 64'(outDATA_arb), 64'd0);
`ifdef SEND_ARB_TIMEOUT_EN
    chk("rst_timeout", 64'(outTIMEOUT_arb), 64'd0);
`endif
    repeat (2) tick();
    rst_arb = 1'b1;
    ptr_m   = 0;
  endtask

  // One full four-phase transfer; the DUT must be able to grant at the next edge.
  task automatic xfer(input int ack_dly, input int hold, input bit early_drop, input bit reassert);
    int            w;
    logic [DW-1:0] d;
    w = rr_model(ptr_m, req_send);
    d = req_data[w];
    grant_log.push_back(w);
    data_log.push_back(d);
    tick();
    chk("send_rise", 64'(outSEND_arb), 64'd1);
    chk("grant", 64'(outGRANT_arb), 64'(oh(w)));
    chk("data", 64'(outDATA_arb), 64'(d));
    chk("ack_idle", 64'(outACK_arb), 64'd0);
    if (early_drop) req_send[w] = 1'b0;
    repeat (ack_dly) begin
      tick();
      chk("send_hold", 64'(outSEND_arb), 64'd1);
      chk("ack_wait", 64'(outACK_arb), 64'd0);
    end
    ACK_arb = 1'b1;
    repeat (SS) begin
      tick();
      chk("ack_sync", 64'(outACK_arb), 64'd0);
    end
    tick();
    chk("ack_rise", 64'(outACK_arb), 64'(oh(w)));
    chk("send_at_ack", 64'(outSEND_arb), 64'd1);
`ifdef SEND_ARB_TIMEOUT_EN
    chk("no_timeout", 64'(outTIMEOUT_arb), 64'd0);
`endif
    if (!early_drop) begin
      repeat (hold) begin
        tick();
        chk("ack_hold", 64'(outACK_arb), 64'(oh(w)));
      end
      req_send[w] = 1'b0;
    end
    tick();
    chk("ack_fall", 64'(outACK_arb), 64'd0);
    chk("send_fall", 64'(outSEND_arb), 64'd0);
    chk("grant_keep", 64'(outGRANT_arb), 64'(oh(w)));
    if (reassert) begin
      req_send[w] = 1'b1;
      req_data[w] = $urandom;
    end
    ACK_arb = 1'b0;
    repeat (SS) begin
      tick();
      chk("grant_drain", 64'(outGRANT_arb), 64'(oh(w)));
    end
    tick();
    chk("grant_clr", 64'(outGRANT_arb), 64'd0);
    chk("data_keep", 64'(outDATA_arb), 64'(d));
    chk("send_idle", 64'(outSEND_arb), 64'd0);
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_vec    = 0;
    n_err    = 0;
    ptr_m    = 0;
    req_send = '0;
    for (int i = 0; i < N; i++) req_data[i] = '0;
    rst_arb  = 1'b0;
    ACK_arb  = 1'b0;
    do_reset();

    // Single request.
    req_send[0] = 1'b1;
    req_data[0] = 32'hDEADBEEF;
    xfer(0, 1, 1'b0, 1'b0);
    chk("single_who", 64'(grant_log[$]), 64'd0);
    chk("single_word", 64'(data_log[$]), 64'hDEADBEEF);

    // Simultaneous requests held through reset, then alternation with req0 re-asserting.
    req_data[0] = 32'h11111111;
    req_data[1] = 32'h22222222;
    req_send    = 3'b011;
    do_reset();
    grant_log.delete();
    data_log.delete();
    xfer(1, 0, 1'b0, 1'b1);
    xfer(0, 2, 1'b0, 1'b1);
    xfer(2, 0, 1'b0, 1'b0);
    xfer(0, 0, 1'b0, 1'b0);
    chk("order0", 64'(grant_log[0]), 64'd0);
    chk("order1", 64'(grant_log[1]), 64'd1);
    chk("order2", 64'(grant_log[2]), 64'd0);
    chk("order3", 64'(grant_log[3]), 64'd1);
    chk("word0", 64'(data_log[0]), 64'h11111111);
    chk("word1", 64'(data_log[1]), 64'h22222222);

    // Reset in WAIT_ACK_HI with the pointer sitting at 1.
    do_reset();
    req_send    = 3'b001;
    req_data[0] = $urandom;
    xfer(0, 0, 1'b0, 1'b0);
    req_send    = 3'b011;
    req_data[0] = $urandom;
    req_data[1] = $urandom;
    w = rr_model(ptr_m, req_send);
    tick();
    chk("pre_rst_grant", 64'(outGRANT_arb), 64'(oh(w)));
    chk("pre_rst_w", 64'(w), 64'd1);
    rst_arb = 1'b0;
    #1;
    chk("midrst_send", 64'(outSEND_arb), 64'd0);
    chk("midrst_ack", 64'(outACK_arb), 64'd0);
    chk("midrst_grant", 64'(outGRANT_arb), 64'd0);
    tick();
    rst_arb = 1'b1;
    ptr_m   = 0;
    xfer(1, 0, 1'b0, 1'b0);
    chk("post_rst_who", 64'(grant_log[$]), 64'd0);

    // Early SEND drop by requester 1.
    xfer(2, 0, 1'b1, 1'b0);
    chk("early_who", 64'(grant_log[$]), 64'd1);

`ifdef SEND_ARB_TIMEOUT_EN
    // Peripheral never acknowledges.
    req_send    = 3'b100;
    req_data[2] = $urandom;
    w = rr_model(ptr_m, req_send);
    tick();
    chk("to_send_rise", 64'(outSEND_arb), 64'd1);
    repeat (TO) begin
      tick();
      chk("to_wait", 64'(outTIMEOUT_arb), 64'd0);
      chk("to_send_hold", 64'(outSEND_arb), 64'd1);
      chk("to_no_ack", 64'(outACK_arb), 64'd0);
    end
    tick();
    chk("to_pulse", 64'(outTIMEOUT_arb), 64'd1);
    chk("to_send_fall", 64'(outSEND_arb), 64'd0);
    chk("to_grant", 64'(outGRANT_arb), 64'(oh(w)));
    chk("to_no_ack2", 64'(outACK_arb), 64'd0);
    req_send[w] = 1'b0;
    tick();
    chk("to_pulse_end", 64'(outTIMEOUT_arb), 64'd0);
    chk("to_grant_clr", 64'(outGRANT_arb), 64'd0);
    chk("to_no_ack3", 64'(outACK_arb), 64'd0);
    ptr_m = (w + 1) % N;
`endif

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      if (req_send == '0 && ($urandom % 2) == 1) begin
        repeat (1 + $urandom % 3) begin
          tick();
          chk("idle_grant", 64'(outGRANT_arb), 64'd0);
          chk("idle_send", 64'(outSEND_arb), 64'd0);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req_send[i] && ($urandom % 2) == 1) begin
          req_send[i] = 1'b1;
          req_data[i] = $urandom;
        end
      end
      if (req_send == '0) begin
        w = int'($urandom % N);
        req_send[w] = 1'b1;
        req_data[w] = $urandom;
      end
      xfer(int'($urandom % 5), int'($urandom % 3), ($urandom % 4) == 0, ($urandom % 2) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
